// File: rtl/nco_sweep_ctrl.sv
// Frequency-sweep sequencer for an NCO: walks the phase-step word from first to last
// in delta increments, holding each word for a programmable number of cycles.
module nco_sweep_ctrl #(
  parameter int ACC_SIZE    = 8,
  parameter int DWELL_WIDTH = 16
) (
  input  logic                   iclk,
  input  logic                   ireset,
  input  logic                   istart,
  input  logic                   iabort,
  input  logic [ACC_SIZE-1:0]    ifirst,
  input  logic [ACC_SIZE-1:0]    ilast,
  input  logic [ACC_SIZE-1:0]    idelta,
  input  logic [DWELL_WIDTH-1:0] idwell,
  output logic [ACC_SIZE-1:0]    ostep,
  output logic                   onCS,
  output logic                   obusy,
  output logic                   odone
);

  typedef enum logic [1:0] {IDLE, DWELL, DONE} state_t;

  typedef struct packed {
    logic [ACC_SIZE-1:0]    last;
    logic [ACC_SIZE-1:0]    delta;
    logic [DWELL_WIDTH-1:0] dwell;
    logic                   up;
  } cfg_t;

  state_t                 state;
  cfg_t                   cfg;
  logic [DWELL_WIDTH-1:0] cnt;
  logic [ACC_SIZE:0]      sum, diff;
  logic [ACC_SIZE-1:0]    nxt;

  // One extra bit catches overflow/borrow; anything at or past last clamps to last.
  always_comb begin
    sum  = {1'b0, ostep} + {1'b0, cfg.delta};
    diff = {1'b0, ostep} - {1'b0, cfg.delta};
    nxt  = cfg.last;
    if (cfg.up) begin
      if (!sum[ACC_SIZE] && (sum[ACC_SIZE-1:0] < cfg.last)) nxt = sum[ACC_SIZE-1:0];
    end else begin
      if (!diff[ACC_SIZE] && (diff[ACC_SIZE-1:0] > cfg.last)) nxt = diff[ACC_SIZE-1:0];
    end
  end

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      state <= IDLE;
      cfg   <= '0;
      cnt   <= '0;
      ostep <= '0;
      onCS  <= 1'b1;
      obusy <= 1'b0;
      odone <= 1'b0;
    end else begin
      odone <= 1'b0;
      case (state)
        IDLE: begin
          onCS  <= 1'b1;
          obusy <= 1'b0;
          if (istart && !iabort) begin
            cfg.last  <= ilast;
            cfg.delta <= (idelta == '0) ? ACC_SIZE'(1) : idelta;
            cfg.dwell <= (idwell == '0) ? DWELL_WIDTH'(1) : idwell;
            cfg.up    <= (ilast >= ifirst);
            cnt       <= (idwell == '0) ? DWELL_WIDTH'(1) : idwell;
            ostep     <= ifirst;
            onCS      <= 1'b0;
            obusy     <= 1'b1;
            state     <= DWELL;
          end
        end
        DWELL: begin
          if (iabort) begin
            onCS  <= 1'b1;
            obusy <= 1'b0;
            state <= IDLE;
          end else if (cnt > DWELL_WIDTH'(1)) begin
            cnt <= cnt - DWELL_WIDTH'(1);
          end else if (ostep != cfg.last) begin
            ostep <= nxt;
            cnt   <= cfg.dwell;
          end else begin
            odone <= 1'b1;
            obusy <= 1'b0;
            onCS  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/nco_sweep_ctrl.md
NCO_SWEEP_CTRL -- requirements
Module: nco_sweep_ctrl

Interface
REQ-001 SHALL have parameter ACC_SIZE, default 8, width of the NCO phase-step word.
REQ-002 SHALL have parameter DWELL_WIDTH, default 16, width of the dwell-count input.
REQ-003 SHALL have port iclk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port ireset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port istart  input  1  one-cycle request to begin a sweep.
REQ-006 SHALL have port iabort  input  1  terminate the sweep in progress.
REQ-007 SHALL have port ifirst  input  ACC_SIZE  first step word of the sweep (unsigned).
REQ-008 SHALL have port ilast  input  ACC_SIZE  final step word of the sweep (unsigned).
REQ-009 SHALL have port idelta  input  ACC_SIZE  step-word increment magnitude (unsigned).
REQ-010 SHALL have port idwell  input  DWELL_WIDTH  number of clock cycles each step word is held.
REQ-011 SHALL have port ostep  output  ACC_SIZE  registered step word driving the downstream NCO step input.
REQ-012 SHALL have port onCS  output  1  registered active-low enable to the NCO; 0 while sweeping.
REQ-013 SHALL have port obusy  output  1  high while a sweep is in progress.
REQ-014 SHALL have port odone  output  1  one-cycle pulse on normal sweep completion.

Function
REQ-015 SHALL implement FSM states IDLE, DWELL, DONE.
REQ-016 In IDLE with istart=1 and iabort=0, SHALL latch ifirst, ilast, idelta, idwell; set ostep=ifirst, onCS=0, obusy=1; enter DWELL (all visible after that same edge).
REQ-017 SHALL derive direction at start: up when ilast >= ifirst, else down; direction fixed for the sweep.
REQ-018 SHALL treat latched idelta=0 as 1 and latched idwell=0 as 1.
REQ-019 SHALL hold each step word on ostep for exactly dwell cycles using a down-counter reloaded on every step change.
REQ-020 At dwell expiry with ostep != latched last, SHALL set ostep to ostep+delta (up) or ostep-delta (down), computed at ACC_SIZE+1 bits.
REQ-021 SHALL saturate the next step to latched last when the computed value passes last or leaves the 0..2^ACC_SIZE-1 range; no wrap-around.
REQ-022 At dwell expiry with ostep == latched last, SHALL enter DONE.
REQ-023 In DONE (one cycle) SHALL drive odone=1, obusy=0, onCS=1, ostep held at last; then enter IDLE.
REQ-024 SHALL ignore istart while in DWELL or DONE; input changes mid-sweep SHALL have no effect.
REQ-025 iabort=1 in DWELL SHALL force IDLE on the next edge: onCS=1, obusy=0, odone stays 0, ostep holds current value.
REQ-026 iabort=1 with istart=1 in IDLE SHALL leave the block in IDLE (abort wins).
REQ-027 In IDLE SHALL hold onCS=1, obusy=0, odone=0, ostep unchanged.
REQ-028 ifirst == ilast SHALL produce a single step of dwell cycles, then DONE.

Reset
REQ-029 ireset=1 SHALL immediately, without a clock edge, set state=IDLE, ostep=0, onCS=1, obusy=0, odone=0, dwell counter=0.
REQ-030 Reset asserted mid-sweep SHALL discard latched configuration; no odone is produced.
REQ-031 After reset release, the first istart SHALL behave per REQ-016 on the next rising edge.

Verification
REQ-032 first=1, last=5, delta=1, dwell=4, istart pulse -> ostep 1,2,3,4,5, each held 4 cycles, onCS=0 for 20 cycles, then odone one cycle, onCS=1.
REQ-033 first=255, last=252, delta=1, dwell=1 -> ostep 255,254,253,252 on consecutive cycles, then odone.
REQ-034 first=1, last=8, delta=3, dwell=2 -> ostep 1,4,7,8 (saturated), then odone; first=250, last=255, delta=10 -> 250,255.
REQ-035 first=0, last=10, dwell=5, iabort two cycles into step 0 -> next edge obusy=0, onCS=1, ostep=0, odone never asserts; second istart during sweep ignored.
REQ-036 ireset pulsed between clock edges mid-sweep -> ostep=0, onCS=1, obusy=0 before next edge; no odone follows.
REQ-037 first=last=7, delta=0, dwell=0 -> ostep=7 for one cycle, then odone one cycle; istart+iabort together in IDLE -> no response.
